// File: rtl/pool_pkg.sv
// pool_pkg: shared definitions for the 2x2 pooling datapath.
//   POOL_DATA_W   - default bits per channel sample
//   POOL_FM_DEPTH - default channels per pixel
//   WIN_TL..WIN_BR - position of each pixel inside a 2x2 window
//   pix_t         - one pixel at the default geometry, as consumed
//                   by the pooling stage
package pool_pkg;

  localparam int POOL_DATA_W   = 16;
  localparam int POOL_FM_DEPTH = 64;

  // Window slot order: top row first, left before right.
  localparam int WIN_TL = 0;
  localparam int WIN_TR = 1;
  localparam int WIN_BL = 2;
  localparam int WIN_BR = 3;

  typedef logic [POOL_DATA_W-1:0] pix_t [POOL_FM_DEPTH];

endpackage : pool_pkg

// File: rtl/pool_line_buf.sv
// pool_line_buf: one-row pixel store for the window generator.
//   clk         - clock; the write happens on the rising edge
//   wr_en_i     - write wr_data_i to entry wr_addr_i
//   wr_addr_i   - column being written
//   wr_data_i   - pixel, all channels
//   rd_addr_i   - odd column of the current pair
//   rd_left_o   - entry at the even column of the pair (combinational)
//   rd_right_o  - entry at rd_addr_i (combinational)
// Contents are never reset: every entry is written in an even row
// before the following odd row reads it.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int FM_DEPTH = POOL_FM_DEPTH,
  parameter int FM_WIDTH = 32,
  parameter int DATA_W   = POOL_DATA_W,
  parameter int CW       = $clog2(FM_WIDTH)
) (
  input  logic                             clk,
  input  logic                             wr_en_i,
  input  logic [CW-1:0]                    wr_addr_i,
  input  logic [FM_DEPTH-1:0][DATA_W-1:0]  wr_data_i,
  input  logic [CW-1:0]                    rd_addr_i,
  output logic [FM_DEPTH-1:0][DATA_W-1:0]  rd_left_o,
  output logic [FM_DEPTH-1:0][DATA_W-1:0]  rd_right_o
);

  logic [FM_DEPTH-1:0][DATA_W-1:0] mem_q [FM_WIDTH];
  logic [CW-1:0]                   left_addr;

  // The pair always starts on an even column, so clearing bit 0 of the
  // odd column gives col-1 without a subtractor.
  assign left_addr = rd_addr_i & ~CW'(1);

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_left_o  = mem_q[left_addr];
  assign rd_right_o = mem_q[rd_addr_i];

endmodule : pool_line_buf

// File: rtl/pool_window_gen.sv
// pool_window_gen: turns a raster-order pixel stream into
// non-overlapping 2x2 windows for the average-pooling stage.
//   clk            - single clock, rising edge
//   rst            - synchronous reset, active high
//   pixel_in_valid - pixel_in is valid this cycle
//   pixel_in_sof   - start of frame, qualified by pixel_in_valid
//   pixel_in       - one pixel, pixel_in[ch]
//   window_valid   - one-cycle pulse per window
//   window_out     - window_out[ch][WIN_TL..WIN_BR]
//   frame_done     - pulses with the last window of a frame
// Handshake: a pixel is transferred on every rising edge where
// pixel_in_valid is 1; there is no ready, the downstream stage always
// accepts window_valid. window_out holds between pulses.
// Even rows go into the line buffer; odd rows pair up with it. The
// left pixel of each odd-row pair waits in prev_pix_q so the window
// can be issued when the right pixel arrives.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int FM_DEPTH  = POOL_FM_DEPTH,
  parameter int FM_WIDTH  = 32,
  parameter int FM_HEIGHT = 32,
  parameter int DATA_W    = POOL_DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  pixel_in_valid,
  input  logic                                  pixel_in_sof,
  input  logic [FM_DEPTH-1:0][DATA_W-1:0]       pixel_in,
  output logic                                  window_valid,
  output logic [FM_DEPTH-1:0][3:0][DATA_W-1:0]  window_out,
  output logic                                  frame_done
);

  localparam int CW = $clog2(FM_WIDTH);
  localparam int RW = $clog2(FM_HEIGHT);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;

  logic          buf_we;
  logic          prev_we;
  logic          emit;
  logic          last_pos;

  logic [FM_DEPTH-1:0][DATA_W-1:0]      prev_pix_q;
  logic [FM_DEPTH-1:0][DATA_W-1:0]      buf_left;
  logic [FM_DEPTH-1:0][DATA_W-1:0]      buf_right;
  logic [FM_DEPTH-1:0][3:0][DATA_W-1:0] window_q, window_d;
  logic                                 valid_q;
  logic                                 done_q;

  pool_line_buf #(
    .FM_DEPTH (FM_DEPTH),
    .FM_WIDTH (FM_WIDTH),
    .DATA_W   (DATA_W),
    .CW       (CW)
  ) u_line_buf (
    .clk        (clk),
    .wr_en_i    (buf_we),
    .wr_addr_i  (eff_col),
    .wr_data_i  (pixel_in),
    .rd_addr_i  (eff_col),
    .rd_left_o  (buf_left),
    .rd_right_o (buf_right)
  );

  always_comb begin
    // A valid SOF pixel overrides wherever the counters were, which
    // silently drops any half-built pair or row.
    eff_col = col_q;
    eff_row = row_q;
    if (pixel_in_valid && pixel_in_sof) begin
      eff_col = '0;
      eff_row = '0;
    end

    col_d   = col_q;
    row_d   = row_q;
    buf_we  = 1'b0;
    prev_we = 1'b0;
    emit    = 1'b0;

    if (pixel_in_valid) begin
      buf_we  = ~eff_row[0];
      prev_we = eff_row[0] & ~eff_col[0];
      emit    = eff_row[0] & eff_col[0];
      if (eff_col == CW'(FM_WIDTH - 1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(FM_HEIGHT - 1)) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
    end

    last_pos = (eff_row == RW'(FM_HEIGHT - 1)) && (eff_col == CW'(FM_WIDTH - 1));

    window_d = window_q;
    if (emit) begin
      for (int ch = 0; ch < FM_DEPTH; ch++) begin
        window_d[ch][WIN_TL] = buf_left[ch];
        window_d[ch][WIN_TR] = buf_right[ch];
        window_d[ch][WIN_BL] = prev_pix_q[ch];
        window_d[ch][WIN_BR] = pixel_in[ch];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      window_q <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      valid_q  <= emit;
      done_q   <= emit & last_pos;
      window_q <= window_d;
    end
  end

  // Left pixel of an odd-row pair; only read after being written.
  always_ff @(posedge clk) begin
    if (prev_we) begin
      prev_pix_q <= pixel_in;
    end
  end

  assign window_valid = valid_q;
  assign frame_done   = done_q;
  assign window_out   = window_q;

endmodule : pool_window_gen

// File: tb/tb_pool_window_gen.sv
module tb_pool_window_gen;

  localparam int FM_DEPTH  = 2;
  localparam int FM_WIDTH  = 4;
  localparam int FM_HEIGHT = 4;
  localparam int DATA_W    = 16;
  localparam int WIN_BITS  = FM_DEPTH * 4 * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                                 pixel_in_valid = 1'b0;
  logic                                 pixel_in_sof   = 1'b0;
  logic [FM_DEPTH-1:0][DATA_W-1:0]      pixel_in       = '0;
  logic                                 window_valid;
  logic [FM_DEPTH-1:0][3:0][DATA_W-1:0] window_out;
  logic                                 frame_done;

  pool_window_gen #(
    .FM_DEPTH  (FM_DEPTH),
    .FM_WIDTH  (FM_WIDTH),
    .FM_HEIGHT (FM_HEIGHT),
    .DATA_W    (DATA_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pixel_in_valid (pixel_in_valid),
    .pixel_in_sof   (pixel_in_sof),
    .pixel_in       (pixel_in),
    .window_valid   (window_valid),
    .window_out     (window_out),
    .frame_done     (frame_done)
  );

  // ---------------- reference values ----------------
  function automatic logic [FM_DEPTH-1:0][DATA_W-1:0] pix_val(input int r, input int c);
    logic [FM_DEPTH-1:0][DATA_W-1:0] p;
    p[0] = 16'(r * 16 + c);
    p[1] = 16'(256 + r * 16 + c);
    return p;
  endfunction

  // Window whose bottom-right pixel is (r,c).
  function automatic logic [WIN_BITS-1:0] win_val(input int r, input int c);
    logic [FM_DEPTH-1:0][3:0][DATA_W-1:0] w;
    for (int ch = 0; ch < FM_DEPTH; ch++) begin
      w[ch][0] = 16'(ch * 256 + (r - 1) * 16 + (c - 1));
      w[ch][1] = 16'(ch * 256 + (r - 1) * 16 + c);
      w[ch][2] = 16'(ch * 256 + r * 16 + (c - 1));
      w[ch][3] = 16'(ch * 256 + r * 16 + c);
    end
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  logic [WIN_BITS:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Requests from the stimulus thread; the monitor performs the check.
  int zero_req = 0, zero_done = 0;
  int drain_req = 0, drain_done = 0;

  logic [WIN_BITS-1:0] last_win;
  logic                prev_valid = 1'b0;

  always @(negedge clk) begin
    logic [WIN_BITS:0] e;
    if (rst) begin
      if (zero_req != zero_done) begin
        zero_done = zero_req;
        checks += 3;
        if (window_valid !== 1'b0) begin
          errors++; $display("FAIL reset_valid: got %b want 0", window_valid);
        end
        if (frame_done !== 1'b0) begin
          errors++; $display("FAIL reset_done: got %b want 0", frame_done);
        end
        if (window_out !== '0) begin
          errors++; $display("FAIL reset_window: got %h want 0", window_out);
        end
      end
      last_win   = window_out;
      prev_valid = 1'b0;
    end else begin
      if (window_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: got fd=%b win=%h want no window", frame_done, window_out);
        end else begin
          e = exp_q.pop_front();
          if ({frame_done, window_out} !== e) begin
            errors++;
            $display("FAIL window: got fd=%b win=%h want fd=%b win=%h",
                     frame_done, window_out, e[WIN_BITS], e[WIN_BITS-1:0]);
          end
        end
        checks++;
        if (prev_valid) begin
          errors++; $display("FAIL valid_width: got 2+ cycles want 1");
        end
      end else begin
        checks++;
        if (window_out !== last_win) begin
          errors++; $display("FAIL hold: got %h want %h", window_out, last_win);
        end
        checks++;
        if (frame_done !== 1'b0) begin
          errors++; $display("FAIL stray_frame_done: got %b want 0", frame_done);
        end
      end
      prev_valid = window_valid;
      last_win   = window_out;
    end
    if (drain_req != drain_done) begin
      drain_done = drain_req;
      checks++;
      if (exp_q.size() != 0) begin
        errors++; $display("FAIL missing_windows: got %0d outstanding want 0", exp_q.size());
      end
      exp_q.delete();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pix(input int r, input int c, input bit sof, input bit ew, input bit efd);
    @(posedge clk); #1;
    pixel_in_valid = 1'b1;
    pixel_in_sof   = sof;
    pixel_in       = pix_val(r, c);
    if (ew) exp_q.push_back({efd, win_val(r, c)});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pixel_in_valid = 1'b0;
      pixel_in_sof   = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    pixel_in_valid = 1'b0;
    pixel_in_sof   = 1'b0;
    @(posedge clk); #1;
    zero_req++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    idle(4);
    drain_req++;
    idle(2);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int r;
    int c;
    bit sof;
    int idle_after;
    bit exp_win;
    bit exp_fd;
  } vec_t;
  vec_t tbl[$];

  task automatic add_frame(input bit with_sof, input bit rand_idle);
    vec_t v;
    for (int r = 0; r < FM_HEIGHT; r++) begin
      for (int c = 0; c < FM_WIDTH; c++) begin
        v.r          = r;
        v.c          = c;
        v.sof        = with_sof && (r == 0) && (c == 0);
        v.idle_after = rand_idle ? int'($urandom_range(1, 3)) : 0;
        v.exp_win    = (r % 2 == 1) && (c % 2 == 1);
        v.exp_fd     = (r == FM_HEIGHT - 1) && (c == FM_WIDTH - 1);
        tbl.push_back(v);
      end
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      send_pix(tbl[i].r, tbl[i].c, tbl[i].sof, tbl[i].exp_win, tbl[i].exp_fd);
      if (tbl[i].idle_after > 0) idle(tbl[i].idle_after);
    end
    tbl.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 zero_req++;
    @(posedge clk); #1;
    rst = 1'b0;

    // Continuous frame with SOF on the first pixel
    add_frame(1'b1, 1'b0);
    run_table();
    drain();

    // Random idle cycles between every pixel
    add_frame(1'b1, 1'b1);
    run_table();
    drain();

    // SOF on the 7th pixel of the stream: the (1,1) window still issues,
    // then the new frame starts over.
    for (int i = 0; i < 6; i++)
      send_pix(i / FM_WIDTH, i % FM_WIDTH, i == 0, i == 5, 1'b0);
    add_frame(1'b1, 1'b0);
    run_table();
    drain();

    // SOF abandons a half-built pair: (1,0) must never form a window
    for (int i = 0; i < 5; i++)
      send_pix(i / FM_WIDTH, i % FM_WIDTH, i == 0, 1'b0, 1'b0);
    add_frame(1'b1, 1'b0);
    run_table();
    drain();

    // Reset after pixel (1,0), then a frame without SOF
    for (int i = 0; i < 5; i++)
      send_pix(i / FM_WIDTH, i % FM_WIDTH, i == 0, 1'b0, 1'b0);
    do_reset();
    add_frame(1'b0, 1'b0);
    run_table();
    drain();

    // Two frames back-to-back, no gaps
    add_frame(1'b1, 1'b0);
    add_frame(1'b1, 1'b0);
    run_table();
    drain();

    // SOF without valid mid-frame is ignored
    for (int i = 0; i < FM_WIDTH * FM_HEIGHT; i++) begin
      int r, c;
      r = i / FM_WIDTH;
      c = i % FM_WIDTH;
      send_pix(r, c, i == 0, (r % 2 == 1) && (c % 2 == 1),
               (r == FM_HEIGHT - 1) && (c == FM_WIDTH - 1));
      if (i == 6) begin
        @(posedge clk); #1;
        pixel_in_valid = 1'b0;
        pixel_in_sof   = 1'b1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pool_window_gen

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Upstream neighbour of the 2x2 average-pooling stage.
- Accepts a raster-order feature-map pixel stream, where each pixel carries FM_DEPTH channels of 16 bits.
- Assembles non-overlapping 2x2 windows and presents each window with a one-cycle valid pulse, in the exact array shape the pooling stage consumes.
- Buffers one even row internally; has no backpressure, because the pooling stage is always ready.

Parameters:
- FM_DEPTH, 64: channels per pixel.
- FM_WIDTH, 32: pixels per row; must be even and at least 2.
- FM_HEIGHT, 32: rows per frame; must be even and at least 2.
- DATA_W, 16: bits per channel sample.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- pixel_in_valid  in  1  pixel_in is valid this cycle.
- pixel_in_sof  in  1  start of frame; qualified by pixel_in_valid.
- pixel_in  in  [DATA_W-1:0] x [FM_DEPTH-1:0]  one pixel, all channels.
- window_valid  out  1  one-cycle pulse; connects to the pooling stage's data_in_valid.
- window_out  out  [DATA_W-1:0] x [FM_DEPTH-1:0][3:0]  2x2 window per channel.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset (rst=1 at a clk edge):
  - col=0, row=0.
  - window_valid=0, frame_done=0, window_out all zero.
  - Line-buffer contents are don't-care and need no reset.
- Position counters:
  - col counts 0..FM_WIDTH-1 and row counts 0..FM_HEIGHT-1, each $clog2 wide.
  - Both advance only on accepted pixels (pixel_in_valid=1).
  - col wraps to 0 and increments row; row wraps to 0 after FM_HEIGHT-1.
- SOF: when pixel_in_valid=1 and pixel_in_sof=1, the pixel is treated as position (0,0) regardless of the counters.
  - Any partial window or row is discarded.
  - pixel_in_sof with pixel_in_valid=0 is ignored.
- Even row (row[0]=0): the pixel is written to line_buf[col]. No output.
- Odd row, even col: the pixel is stored in the left-pixel register prev_pix. No output.
- Odd row, odd col: a window is emitted. Registered outputs update at the next edge:
  - window_out[ch][0] = line_buf[col-1][ch] (top-left)
  - window_out[ch][1] = line_buf[col][ch] (top-right)
  - window_out[ch][2] = prev_pix[ch] (bottom-left)
  - window_out[ch][3] = pixel_in[ch] (bottom-right)
  - window_valid=1 for exactly one cycle.
- Latency: window_valid is high in the cycle after the bottom-right pixel is accepted.
- window_out holds its last value while window_valid=0.
- frame_done=1 in the same cycle as the window whose bottom-right pixel is (FM_HEIGHT-1, FM_WIDTH-1).
- Idle cycles (pixel_in_valid=0) may occur anywhere, including between the two pixels of a pair. State is held across them.
- Throughput: one pixel per cycle sustained. This gives at most one window every 2 cycles, and (FM_WIDTH/2)*(FM_HEIGHT/2) windows per frame.
- Data is passed through bit-exact; no arithmetic on samples.
- Reset mid-row: all counters return to 0 and any pending window is dropped. The next accepted pixel is (0,0).
- Back-to-back frames: pixel (0,0) of the next frame may arrive in the cycle right after the last pixel. The final window and frame_done still emit normally.

Decomposition:
- Package pool_pkg holds:
  - the DATA_W default;
  - the window index constants WIN_TL=0, WIN_TR=1, WIN_BL=2, WIN_BR=3;
  - a pixel typedef, pix_t = logic [DATA_W-1:0] [FM_DEPTH], shared with the pooling stage.
- One sub-module, pool_line_buf:
  - FM_WIDTH-entry register array of pix_t with one write port;
  - two combinational read ports (col-1 and col);
  - no reset.

Test Plan (FM_DEPTH=2, FM_WIDTH=4, FM_HEIGHT=4; channel 0 sample = row*16+col, channel 1 sample = 256+row*16+col):
- Continuous frame with sof on the first pixel:
  - 4 windows; the first appears the cycle after pixel (1,1), with ch0 = {0,1,16,17} and ch1 = {256,257,272,273}.
  - The last window is ch0 = {34,35,50,51} with frame_done=1.
- Random idle cycles inserted between every pixel: same 4 windows, same values; each window_valid is exactly 1 cycle wide.
- pixel_in_sof asserted on the stream's 7th pixel (mid row 1):
  - no window for the aborted pair;
  - the following 16 pixels produce 4 correct windows and one frame_done.
- rst pulsed after pixel (1,0):
  - all outputs are 0 the next cycle;
  - a fresh frame then yields first window {0,1,16,17}.
- Two frames back-to-back without gaps:
  - 8 windows and two frame_done pulses, on windows 4 and 8;
  - window_out is stable between pulses.
- pixel_in_sof with pixel_in_valid=0 mid-frame: ignored; the frame completes unchanged.
